// File: rtl/mux_rr_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_stream
//  Purpose  : N-channel, W-bit streaming multiplexer. A rotating-pointer
//             round-robin arbiter picks one valid producer per cycle and the
//             winning beat is captured in a one-entry registered output stage
//             with a valid/ready handshake toward the consumer.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N     : number of input channels (2..16, any value)
//    W     : data width per channel
//    SELW  : (derived) width of a channel index, $clog2(N)
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous active-high reset
//    in_data    in   N*W    channel k at bits [k*W +: W]
//    in_valid   in   N      per-channel valid
//    in_ready   out  N      per-channel ready, combinational, one-hot or zero
//    out_data   out  W      registered selected data
//    out_ch     out  SELW   registered index of the supplying channel
//    out_valid  out  1      registered valid
//    out_ready  in   1      consumer ready
//    force_en   in   1      (MUX_FORCE_SEL_EN only) restrict grant to force_sel
//    force_sel  in   SELW   (MUX_FORCE_SEL_EN only) forced channel index
//  Build option
//    MUX_FORCE_SEL_EN : adds force_en/force_sel. A forced load leaves the
//                       round-robin pointer untouched.
// ============================================================================
module mux_rr_stream #(
   parameter int  N    = 4,
   parameter int  W    = 8,
   localparam int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready
`ifdef MUX_FORCE_SEL_EN
   ,
   input  logic              force_en,
   input  logic [SELW-1:0]   force_sel
`endif
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SELW-1:0]   r_ptr;
   logic [SELW-1:0]   r_ch;
   logic [W-1:0]      r_data;

   logic [N-1:0]      w_eligible;
   logic [SELW-1:0]   w_grant;
   logic              w_found;
   logic              w_space;
   logic              w_load;
   logic              w_ptr_upd;
   logic [SELW-1:0]   w_ptr_nxt;
   logic [W-1:0]      w_sel_data;
   int                w_best;
   int                w_dist;

   // ------------------------------------------------------------------------
   // Eligibility: normally every valid channel; with forcing enabled only the
   // forced index. An out-of-range force_sel matches no k and so grants none.
   // ------------------------------------------------------------------------
   always_comb begin
      w_eligible = in_valid;
`ifdef MUX_FORCE_SEL_EN
      if (force_en) begin
         for (int k = 0; k < N; k++) begin
            w_eligible[k] = in_valid[k] && (force_sel == SELW'(k));
         end
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Round-robin search: the winner is the eligible channel with the smallest
   // cyclic distance from the pointer. The distance uses an explicit modulo-N
   // wrap so non-power-of-2 channel counts rotate correctly.
   // ------------------------------------------------------------------------
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_best  = N;
      w_dist  = 0;
      for (int k = 0; k < N; k++) begin
         w_dist = (k >= int'(r_ptr)) ? (k - int'(r_ptr)) : (k + N - int'(r_ptr));
         if (w_eligible[k] && (w_dist < w_best)) begin
            w_best  = w_dist;
            w_found = 1'b1;
            w_grant = SELW'(k);
         end
      end
   end

   // Output stage can take a beat when empty or when it drains this cycle.
   assign w_space = (r_state == ST_EMPTY) || out_ready;
   assign w_load  = w_found && w_space;

`ifdef MUX_FORCE_SEL_EN
   assign w_ptr_upd = w_load && !force_en;
`else
   assign w_ptr_upd = w_load;
`endif

   assign w_ptr_nxt = (int'(w_grant) == N - 1) ? '0 : (w_grant + 1'b1);

   always_comb begin
      in_ready   = '0;
      w_sel_data = '0;
      for (int k = 0; k < N; k++) begin
         in_ready[k] = w_load && (w_grant == SELW'(k));
         if (w_grant == SELW'(k)) begin
            w_sel_data = in_data[k*W +: W];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output-stage occupancy FSM
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
         ST_FULL:  if (!w_load && out_ready) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Data and channel hold their last value when the stage drains empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_ch   <= '0;
         r_ptr  <= '0;
      end else begin
         if (w_load) begin
            r_data <= w_sel_data;
            r_ch   <= w_grant;
         end
         if (w_ptr_upd) begin
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign out_valid = (r_state == ST_FULL);

endmodule
`default_nettype wire
